vote_controller: RTL and testbench
==================================

VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 Parameter NUM_CAND, default 4: number of candidates, 2..4.
REQ-002 Parameter TALLY_W, default 8: width of each candidate tally.
REQ-003 Parameter RESP_TIMEOUT, default 4: cycles to wait for a checker response.
REQ-004 Parameter VOTE_TIMEOUT, default 255: cycles to wait for a vote.
REQ-005 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-006 voter_id  in  4  voter ID presented with id_submit.
REQ-007 id_submit  in  1  single-cycle request to start a session.
REQ-008 cand_sel  in  2  candidate index presented with vote_submit.
REQ-009 vote_submit  in  1  single-cycle ballot strobe.
REQ-010 id_valid, id_used  in  1 each  checker response, valid one cycle after check.
REQ-011 check  out  1  checker query strobe.
REQ-012 mark_done  out  1  checker mark strobe.
REQ-013 id_out  out  4  ID driven to the checker.
REQ-014 busy  out  1  high whenever the controller is not in IDLE.
REQ-015 vote_ok, rejected, invalid_cand, timed_out  out  1 each  single-cycle status pulses.
REQ-016 tally_sel  in  2 and tally_out  out  TALLY_W: combinational tally read port.
REQ-017 total_votes  out  TALLY_W+2  count of accepted votes.

Function
REQ-018 The FSM SHALL have the states IDLE, CHECK, WAIT_RESP, WAIT_VOTE and COMMIT.
REQ-019 IDLE: on id_submit, latch voter_id into id_out and move to CHECK; ignore id_submit in every other state.
REQ-020 CHECK: assert check for exactly one cycle, then move to WAIT_RESP.
REQ-021 WAIT_RESP: on id_valid, move to WAIT_VOTE; on id_used, pulse rejected and return to IDLE.
REQ-022 WAIT_RESP: if neither response arrives within RESP_TIMEOUT cycles, pulse timed_out and return to IDLE.
REQ-023 WAIT_VOTE: on vote_submit with cand_sel < NUM_CAND, increment tally[cand_sel] and total_votes, then move to COMMIT.
REQ-024 WAIT_VOTE: on vote_submit with cand_sel >= NUM_CAND, pulse invalid_cand, leave all tallies unchanged and stay in WAIT_VOTE.
REQ-025 COMMIT: assert mark_done and pulse vote_ok for exactly one cycle, then return to IDLE.
REQ-026 Latency from id_submit to check SHALL be 1 cycle; latency from vote_submit to mark_done SHALL be 1 cycle.
REQ-027 id_out SHALL hold stable from the CHECK state through the COMMIT state.
REQ-028 Tallies SHALL saturate at 2^TALLY_W-1; total_votes SHALL saturate at its maximum value.
REQ-029 check and mark_done SHALL never be asserted in the same cycle.
REQ-030 vote_submit outside WAIT_VOTE SHALL be ignored.
REQ-031 If id_valid and id_used are both high, id_used SHALL take priority.

Reset
REQ-032 Reset SHALL force IDLE and clear all tallies, total_votes, id_out and timers, and drive every strobe and pulse output to 0.
REQ-033 Reset mid-session SHALL abort the session without asserting mark_done.

Configuration
REQ-034 Macro VOTE_TIMEOUT_EN defined: if WAIT_VOTE lasts VOTE_TIMEOUT cycles without a valid vote, pulse timed_out and return to IDLE without asserting mark_done, so the voter can retry.
REQ-035 VOTE_TIMEOUT_EN undefined: WAIT_VOTE waits indefinitely and no vote timer is built.

Structure
REQ-036 Package vote_pkg SHALL hold the state enum, the ID width (4) and the candidate index width (2).
REQ-037 The tally counter bank SHALL be a separate sub-module, vote_tally (per-candidate saturating counters plus the total counter).

Verification
REQ-038 Happy path: id 5, check response id_valid, then vote cand 2 -> check at cycle +1, mark_done with id_out=5, tally[2]=1, total_votes=1, vote_ok pulse.
REQ-039 Repeat voter: id 5 with response id_used -> rejected pulse, no mark_done, all tallies unchanged.
REQ-040 Invalid candidate: NUM_CAND=3, vote cand 3 -> invalid_cand pulse and the FSM stays in WAIT_VOTE; then cand 0 -> tally[0]=1.
REQ-041 Checker silence: no response after check -> timed_out pulse on the 4th cycle of WAIT_RESP and return to IDLE.
REQ-042 Saturation: 260 sessions voting cand 1 with TALLY_W=8 -> tally[1]=255 and total_votes=260.
REQ-043 Reset during WAIT_VOTE -> IDLE next cycle, no mark_done, all tallies 0; with VOTE_TIMEOUT_EN, an idle voter -> timed_out after 255 cycles.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and widths for the vote controller slice.
package vote_pkg;
    localparam int ID_W     = 4;
    localparam int CAND_W   = 2;
    localparam int MAX_CAND = 1 << CAND_W;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_RESP,
        WAIT_VOTE,
        COMMIT
    } state_e;
endpackage

// File: rtl/vote_if.sv
// Voter-ID checker link: query/mark strobes out, one-cycle-later response back.
interface vote_if;
    import vote_pkg::*;

    logic            check;
    logic            mark_done;
    logic [ID_W-1:0] id_out;
    logic            id_valid;
    logic            id_used;

    modport master (output check, output mark_done, output id_out,
                    input  id_valid, input id_used);
    modport slave  (input  check, input mark_done, input id_out,
                    output id_valid, output id_used);
endinterface

// File: rtl/vote_tally.sv
// Per-candidate saturating tallies plus a saturating total, with a combinational read port.
module vote_tally
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int TALLY_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_i,
    input  logic [CAND_W-1:0]   cand_i,
    input  logic [CAND_W-1:0]   tally_sel_i,
    output logic [TALLY_W-1:0]  tally_o,
    output logic [TALLY_W+1:0]  total_o
);
    logic [TALLY_W-1:0] tally_w [MAX_CAND];
    logic [TALLY_W+1:0] total_q;

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar c = 0; c < MAX_CAND; c++) begin : g_cand
        if (c < NUM_CAND) begin : g_live
            logic [TALLY_W-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (reset)
                    cnt_q <= '0;
                else if (inc_i && cand_i == CAND_W'(c))
                    cnt_q <= sat_inc(cnt_q);
            end
            assign tally_w[c] = cnt_q;
        end else begin : g_absent
            assign tally_w[c] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            total_q <= '0;
        else if (inc_i && !(&total_q))
            total_q <= total_q + 1'b1;
    end

    assign tally_o = tally_w[tally_sel_i];
    assign total_o = total_q;
endmodule

// File: rtl/vote_controller.sv
// Voting session controller: ID check, ballot capture, commit to the checker.
// Optional macro VOTE_TIMEOUT_EN adds an abandoned-ballot timeout in WAIT_VOTE.
module vote_controller
    import vote_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int TALLY_W      = 8,
    parameter int RESP_TIMEOUT = 4,
    parameter int VOTE_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_W-1:0]     voter_id_i,
    input  logic                id_submit_i,
    input  logic [CAND_W-1:0]   cand_sel_i,
    input  logic                vote_submit_i,
    vote_if.master              chk,
    output logic                busy_o,
    output logic                vote_ok_o,
    output logic                rejected_o,
    output logic                invalid_cand_o,
    output logic                timed_out_o,
    input  logic [CAND_W-1:0]   tally_sel_i,
    output logic [TALLY_W-1:0]  tally_out_o,
    output logic [TALLY_W+1:0]  total_votes_o
);
    localparam int                RT_W      = $clog2(RESP_TIMEOUT + 1);
    localparam logic [RT_W-1:0]   RESP_LAST = RT_W'(RESP_TIMEOUT - 1);
    localparam logic [CAND_W:0]   NCAND     = NUM_CAND[CAND_W:0];

    state_e          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [RT_W-1:0] rt_q, rt_d;
    logic            check_c, mark_c, inc_c, cand_ok;

`ifdef VOTE_TIMEOUT_EN
    localparam int              VT_W      = $clog2(VOTE_TIMEOUT + 1);
    localparam logic [VT_W-1:0] VOTE_LAST = VT_W'(VOTE_TIMEOUT - 1);
    logic [VT_W-1:0] vt_q, vt_d;
`endif

    assign cand_ok = {1'b0, cand_sel_i} < NCAND;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            rt_q    <= '0;
`ifdef VOTE_TIMEOUT_EN
            vt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rt_q    <= rt_d;
`ifdef VOTE_TIMEOUT_EN
            vt_q    <= vt_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        rt_d           = rt_q;
`ifdef VOTE_TIMEOUT_EN
        vt_d           = vt_q;
`endif
        check_c        = 1'b0;
        mark_c         = 1'b0;
        inc_c          = 1'b0;
        vote_ok_o      = 1'b0;
        rejected_o     = 1'b0;
        invalid_cand_o = 1'b0;
        timed_out_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_submit_i) begin
                    id_d    = voter_id_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                check_c = 1'b1;
                rt_d    = '0;
                state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                // id_used outranks id_valid when the checker raises both
                if (chk.id_used) begin
                    rejected_o = 1'b1;
                    state_d    = IDLE;
                end else if (chk.id_valid) begin
                    state_d = WAIT_VOTE;
`ifdef VOTE_TIMEOUT_EN
                    vt_d    = '0;
`endif
                end else if (rt_q == RESP_LAST) begin
                    timed_out_o = 1'b1;
                    state_d     = IDLE;
                end else begin
                    rt_d = rt_q + 1'b1;
                end
            end
            WAIT_VOTE: begin
                if (vote_submit_i && cand_ok) begin
                    inc_c   = 1'b1;
                    state_d = COMMIT;
                end else begin
                    invalid_cand_o = vote_submit_i;
`ifdef VOTE_TIMEOUT_EN
                    if (vt_q == VOTE_LAST) begin
                        timed_out_o = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        vt_d = vt_q + 1'b1;
                    end
`endif
                end
            end
            COMMIT: begin
                mark_c    = 1'b1;
                vote_ok_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset is synchronous, so quiet every strobe during the reset cycle itself
        if (reset) begin
            check_c        = 1'b0;
            mark_c         = 1'b0;
            inc_c          = 1'b0;
            vote_ok_o      = 1'b0;
            rejected_o     = 1'b0;
            invalid_cand_o = 1'b0;
            timed_out_o    = 1'b0;
        end
    end

    assign chk.check     = check_c;
    assign chk.mark_done = mark_c;
    assign chk.id_out    = id_q;
    assign busy_o        = (state_q != IDLE);

    vote_tally #(
        .NUM_CAND (NUM_CAND),
        .TALLY_W  (TALLY_W)
    ) u_tally (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (inc_c),
        .cand_i      (cand_sel_i),
        .tally_sel_i (tally_sel_i),
        .tally_o     (tally_out_o),
        .total_o     (total_votes_o)
    );
endmodule

// File: tb/tb_vote_controller.sv
// Bench for vote_controller: directed and randomized sessions against a tally model.
module tb_vote_controller;
    localparam int NC = 3;
    localparam int TW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] voter_id;
    logic       id_submit;
    logic [1:0] cand_sel;
    logic       vote_submit;
    logic       busy, vote_ok, rejected, invalid_cand, timed_out;
    logic [1:0] tally_sel;
    logic [TW-1:0] tally_out;
    logic [TW+1:0] total_votes;

    int vectors = 0;
    int miscompares = 0;
    int m_tally [4];
    int m_total;

    vote_if chk_bus ();

    vote_controller #(
        .NUM_CAND(NC), .TALLY_W(TW), .RESP_TIMEOUT(4), .VOTE_TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .voter_id_i(voter_id), .id_submit_i(id_submit),
        .cand_sel_i(cand_sel), .vote_submit_i(vote_submit), .chk(chk_bus),
        .busy_o(busy), .vote_ok_o(vote_ok), .rejected_o(rejected),
        .invalid_cand_o(invalid_cand), .timed_out_o(timed_out),
        .tally_sel_i(tally_sel), .tally_out_o(tally_out), .total_votes_o(total_votes)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) m_tally[c] = 0;
        m_total = 0;
    endtask

    task automatic model_vote(input int c);
        if (m_tally[c] < (1 << TW) - 1) m_tally[c]++;
        if (m_total < (1 << (TW + 2)) - 1) m_total++;
    endtask

    // Called right after step(); reads all tallies before the next edge
    task automatic check_tallies();
        for (int c = 0; c < 4; c++) begin
            tally_sel = c[1:0];
            #1;
            cmp($sformatf("tally[%0d]", c), tally_out, m_tally[c]);
        end
        cmp("total_votes", total_votes, m_total);
    endtask

    // resp: 0 valid, 1 used, 2 both, 3 silent; starts and ends one unit after a rising edge
    task automatic session(input logic [3:0] id, input int resp, input int n_bad, input logic [1:0] cand);
        voter_id = id; id_submit = 1'b1;
        #2; cmp("idle_busy", busy, 0);
        step(); id_submit = 1'b0; voter_id = 4'($urandom);
        #2; cmp("check", chk_bus.check, 1); cmp("check_mark", chk_bus.mark_done, 0);
        cmp("id_out_chk", chk_bus.id_out, id); cmp("busy", busy, 1);
        step();
        if (resp == 3) begin
            for (int k = 0; k < 4; k++) begin
                #2; cmp("resp_timeout", timed_out, (k == 3)); cmp("check_once", chk_bus.check, 0);
                step();
            end
            #2; cmp("timeout_idle", busy, 0);
            step();
            return;
        end
        chk_bus.id_valid = (resp == 0 || resp == 2);
        chk_bus.id_used  = (resp == 1 || resp == 2);
        vote_submit = 1'b1; cand_sel = 2'd0;
        #2; cmp("rejected", rejected, chk_bus.id_used); cmp("no_timeout", timed_out, 0);
        step();
        chk_bus.id_valid = 1'b0; chk_bus.id_used = 1'b0; vote_submit = 1'b0;
        if (resp != 0) begin
            #2; cmp("reject_idle", busy, 0); cmp("reject_nomark", chk_bus.mark_done, 0);
            step();
            return;
        end
        for (int b = 0; b < n_bad; b++) begin
            vote_submit = 1'b1; cand_sel = 2'd3;
            #2; cmp("invalid_cand", invalid_cand, 1); cmp("stay_wait", busy, 1);
            cmp("bad_nomark", chk_bus.mark_done, 0);
            step();
        end
        vote_submit = 1'b1; cand_sel = cand;
        #2; cmp("valid_noinv", invalid_cand, 0); cmp("early_mark", chk_bus.mark_done, 0);
        step(); vote_submit = 1'b0;
        #2; cmp("mark_done", chk_bus.mark_done, 1); cmp("vote_ok", vote_ok, 1);
        cmp("commit_nocheck", chk_bus.check, 0); cmp("id_out_commit", chk_bus.id_out, id);
        model_vote(cand);
        step();
        #2; cmp("done_idle", busy, 0); cmp("vote_ok_once", vote_ok, 0);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset = 1'b1; voter_id = '0; id_submit = 1'b0; cand_sel = '0; vote_submit = 1'b0;
        tally_sel = '0; chk_bus.id_valid = 1'b0; chk_bus.id_used = 1'b0;
        model_clear();
        do_reset();
        #2;
        cmp("rst_busy", busy, 0); cmp("rst_check", chk_bus.check, 0);
        cmp("rst_mark", chk_bus.mark_done, 0); cmp("rst_id_out", chk_bus.id_out, 0);
        cmp("rst_pulses", {vote_ok, rejected, invalid_cand, timed_out}, 0);
        step(); check_tallies();

        session(4'd5, 0, 0, 2'd2); check_tallies();
        session(4'd5, 1, 0, 2'd0); check_tallies();
        session(4'd7, 2, 0, 2'd1); check_tallies();
        session(4'd9, 0, 1, 2'd0); check_tallies();
        session(4'd3, 3, 0, 2'd0); check_tallies();

        for (int i = 0; i < 40; i++) begin
            session(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    2'($urandom_range(0, NC - 1)));
            check_tallies();
        end

        do_reset();
        for (int i = 0; i < 260; i++) session(4'($urandom), 0, 0, 2'd1);
        check_tallies();

        // Reset while a ballot is pending
        voter_id = 4'd11; id_submit = 1'b1; step(); id_submit = 1'b0;
        step();
        chk_bus.id_valid = 1'b1; step(); chk_bus.id_valid = 1'b0;
        reset = 1'b1; vote_submit = 1'b1; cand_sel = 2'd0;
        #2; cmp("rst_mid_mark", chk_bus.mark_done, 0); cmp("rst_mid_ok", vote_ok, 0);
        step(); reset = 1'b0; vote_submit = 1'b0; model_clear();
        #2; cmp("rst_mid_idle", busy, 0); cmp("rst_mid_mark2", chk_bus.mark_done, 0);
        step(); check_tallies();

        // Voter goes quiet in WAIT_VOTE
        voter_id = 4'd6; id_submit = 1'b1; step(); id_submit = 1'b0;
        step();
        chk_bus.id_valid = 1'b1; step(); chk_bus.id_valid = 1'b0;
`ifdef VOTE_TIMEOUT_EN
        for (int k = 0; k < 255; k++) begin
            #2;
            if (k == 254 || k % 50 == 0) cmp("vote_timeout", timed_out, (k == 254));
            if (k % 50 == 0) cmp("vt_nomark", chk_bus.mark_done, 0);
            step();
        end
        #2; cmp("vt_idle", busy, 0); cmp("vt_nomark_end", chk_bus.mark_done, 0);
        step();
`else
        for (int k = 0; k < 300; k++) begin
            #2;
            if (k % 50 == 0 || k == 299) begin
                cmp("wait_forever", busy, 1); cmp("no_vote_timeout", timed_out, 0);
            end
            step();
        end
        vote_submit = 1'b1; cand_sel = 2'd2; step(); vote_submit = 1'b0;
        #2; cmp("late_mark", chk_bus.mark_done, 1); model_vote(2);
        step();
`endif
        step(); check_tallies();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
